// File: rtl/sticky_priority_arbiter.sv
// sticky_priority_arbiter
//   Captures request pulses into a sticky pending register and issues them
//   one at a time as registered indices over a valid/ready interface. The
//   interface adds per-line masking, a flush input, and a saturating count
//   of request collisions.
//   The default winner is the highest pending, unmasked index.
//   When the macro RR_PRIORITY_EN is defined, a round-robin pointer makes
//   the most recent winner the lowest priority.
module sticky_priority_arbiter #(
   parameter  int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req_i,
   input  logic [WIDTH-1:0] mask_i,
   input  logic             clr_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] pending_o,
   output logic [7:0]       drop_cnt
);

   logic [WIDTH-1:0] pending_reg,   pending_next;
   logic             out_valid_reg, out_valid_next;
   logic [IDX_W-1:0] out_idx_reg,   out_idx_next;
   logic [7:0]       drop_cnt_reg,  drop_cnt_next;

   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] grant_vec;
   logic [IDX_W-1:0] win_idx;
   logic             slot_free;
   logic             grant;
   logic             collision;

   // Only registered requests compete, so a pulse is never granted in the
   // cycle that it arrives.
   assign slot_free = !out_valid_reg || out_ready;
   assign cand      = pending_reg & mask_i;
   assign grant     = slot_free && (|cand) && !clr_i;

`ifdef RR_PRIORITY_EN
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

   // Round-robin search: rr_ptr first, then downward, wrapping to WIDTH-1
   always_comb begin
      int  pos;
      logic hit;
      pos     = 0;
      hit     = 1'b0;
      win_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pos = (int'(rr_ptr_reg) + WIDTH - i) % WIDTH;
         if (!hit && cand[pos[IDX_W-1:0]]) begin
            win_idx = pos[IDX_W-1:0];
            hit     = 1'b1;
         end
      end
   end

   // After a grant, the winner becomes the lowest priority.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant) begin
         rr_ptr_next = (win_idx == '0) ? IDX_W'(WIDTH - 1) : win_idx - IDX_W'(1);
      end
   end
`else
   // Fixed priority: the highest set candidate index wins.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cand[i]) win_idx = IDX_W'(i);
      end
   end
`endif

   // One-hot version of the granted line, used to retire its pending bit
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_grant
      assign grant_vec[gi] = grant && (win_idx == IDX_W'(gi));
   end

   // A new pulse on an already-pending line, other than the line just
   // granted, is a collision.
   assign collision = |(req_i & pending_reg & ~grant_vec);

   // Next-state logic. A flush drops pending requests and the output slot.
   // It leaves out_idx and the counter unchanged.
   always_comb begin
      pending_next   = (pending_reg & ~grant_vec) | req_i;
      out_valid_next = out_valid_reg;
      out_idx_next   = out_idx_reg;
      drop_cnt_next  = drop_cnt_reg;
      if (clr_i) begin
         pending_next   = '0;
         out_valid_next = 1'b0;
      end else begin
         if (grant) begin
            out_valid_next = 1'b1;
            out_idx_next   = win_idx;
         end else if (slot_free) begin
            out_valid_next = 1'b0;
         end
         if (collision && drop_cnt_reg != 8'hFF) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg   <= '0;
         out_valid_reg <= 1'b0;
         out_idx_reg   <= '0;
         drop_cnt_reg  <= '0;
`ifdef RR_PRIORITY_EN
         rr_ptr_reg    <= IDX_W'(WIDTH - 1);
`endif
      end else begin
         pending_reg   <= pending_next;
         out_valid_reg <= out_valid_next;
         out_idx_reg   <= out_idx_next;
         drop_cnt_reg  <= drop_cnt_next;
`ifdef RR_PRIORITY_EN
         rr_ptr_reg    <= rr_ptr_next;
`endif
      end
   end

   assign out_valid = out_valid_reg;
   assign out_idx   = out_idx_reg;
   assign pending_o = pending_reg;
   assign drop_cnt  = drop_cnt_reg;

endmodule
